step_pulse_rx: RTL and testbench

STEP_PULSE_RX -- requirements
Module: step_pulse_rx

---
 rtl/step_pulse_rx_if.sv | 27 ++
 rtl/step_pulse_rx.sv | 162 ++++++++++++++++
 tb/tb_step_pulse_rx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_rx_if.sv
// Step/direction receiver bus: asynchronous step/dir inputs, control strobes,
// and the position/timing/status results.
interface step_pulse_rx_if;
    logic        step_in;
    logic        dir_in;
    logic        clr;
    logic        target_p;
    logic [23:0] target;
    logic [26:0] idle_lim;
    logic [31:0] pos;
    logic [23:0] pulse_cnt;
    logic [26:0] period;
    logic        period_vld;
    logic        busy;
    logic        done;
    logic        dir_err;

    modport master (
        output step_in, dir_in, clr, target_p, target, idle_lim,
        input  pos, pulse_cnt, period, period_vld, busy, done, dir_err
    );

    modport slave (
        input  step_in, dir_in, clr, target_p, target, idle_lim,
        output pos, pulse_cnt, period, period_vld, busy, done, dir_err
    );
endinterface

// File: rtl/step_pulse_rx.sv
// Step/direction pulse-train receiver: synchronizes step/dir, tracks signed
// position, pulse count and step period, flags idle timeout, target reach and
// direction changes during a step-high phase.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | no train in progress (busy=0); first rise has no period
//   ACTIVE | train in progress (busy=1); rises produce period strobes
module step_pulse_rx #(
    parameter int SYNC_STG = 2
) (
    input logic           Clk100m,
    input logic           Rstn,
    step_pulse_rx_if.slave bus
);

    localparam logic [26:0] PER_MAX = '1;
    localparam logic [23:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STG-1:0] step_sh;
    logic [SYNC_STG-1:0] dir_sh;
    logic                step_prev;
    logic                dir_prev;
    logic                step_s;
    logic                dir_s;
    logic                rise;

    logic [31:0] pos;
    logic [23:0] pulse_cnt;
    logic [26:0] per_cnt;
    logic [26:0] period;
    logic        period_vld;
    logic        dir_err;
    logic        busy;

    logic [23:0] target_q;
    logic        armed;
    logic        done;

    assign step_s = step_sh[SYNC_STG-1];
    assign dir_s  = dir_sh[SYNC_STG-1];
    assign rise   = step_s & ~step_prev;

    // Synchronizer chains plus one extra copy of each for edge/change detection
    always_ff @(posedge Clk100m or negedge Rstn) begin
        if (!Rstn) begin
            step_sh   <= '0;
            dir_sh    <= '0;
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
        end else begin
            step_sh   <= {step_sh[SYNC_STG-2:0], bus.step_in};
            dir_sh    <= {dir_sh[SYNC_STG-2:0], bus.dir_in};
            step_prev <= step_s;
            dir_prev  <= dir_s;
        end
    end

    // Position, pulse count, period measurement and direction-error flag
    always_ff @(posedge Clk100m or negedge Rstn) begin
        if (!Rstn) begin
            pos        <= '0;
            pulse_cnt  <= '0;
            per_cnt    <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            dir_err    <= 1'b0;
        end else if (bus.clr) begin
            // period is deliberately kept so software can still read the last rate
            pos        <= '0;
            pulse_cnt  <= '0;
            per_cnt    <= '0;
            period_vld <= 1'b0;
            dir_err    <= 1'b0;
        end else begin
            period_vld <= rise & busy;
            if (rise) begin
                per_cnt <= '0;
                pos     <= dir_s ? (pos - 32'd1) : (pos + 32'd1);
                if (pulse_cnt != CNT_MAX)
                    pulse_cnt <= pulse_cnt + 24'd1;
                if (busy)
                    period <= (per_cnt == PER_MAX) ? PER_MAX : (per_cnt + 27'd1);
            end else if (per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + 27'd1;
            end
            if (step_s && (dir_s != dir_prev))
                dir_err <= 1'b1;
        end
    end

    // Target register and one-shot done; target_p loads even during clr
    always_ff @(posedge Clk100m or negedge Rstn) begin
        if (!Rstn) begin
            target_q <= '0;
            armed    <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.clr) begin
                armed <= 1'b0;
            end else if (armed && (pulse_cnt == target_q)) begin
                done  <= 1'b1;
                armed <= 1'b0;
            end
            if (bus.target_p) begin
                target_q <= bus.target;
                armed    <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clk100m or negedge Rstn) begin
        if (!Rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state: enter on a rise, leave on idle timeout or clr
    always_comb begin
        state_nxt = state;
        if (bus.clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:
                    if (rise)
                        state_nxt = ACTIVE;
                ACTIVE:
                    if ((bus.idle_lim != '0) && (per_cnt == bus.idle_lim) && !rise)
                        state_nxt = IDLE;
                default:
                    state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        if (state == ACTIVE)
            busy = 1'b1;
    end

    assign bus.pos        = pos;
    assign bus.pulse_cnt  = pulse_cnt;
    assign bus.period     = period;
    assign bus.period_vld = period_vld;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.dir_err    = dir_err;

endmodule

// File: tb/tb_step_pulse_rx.sv
// Bench for step_pulse_rx: table of pulse trains plus hand sequences for
// latency, target, idle timeout, dir error, clr collisions and reset.
module tb_step_pulse_rx;

    logic Clk100m;
    logic Rstn;

    step_pulse_rx_if bus ();

    step_pulse_rx #(.SYNC_STG(2)) dut (
        .Clk100m (Clk100m),
        .Rstn    (Rstn),
        .bus     (bus)
    );

    initial Clk100m = 1'b0;
    always #5 Clk100m = ~Clk100m;

    typedef struct {
        bit          dir;
        int          n;
        int          hi;
        int          lo;
        logic [31:0] pos;
        logic [23:0] cnt;
        logic [26:0] period;
        int          nvld;
    } vec_t;

    vec_t vecs [5];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int cnt4_cyc = -1;
    int cnt_chg_cyc = -1;
    int busy_fall_cyc = -1;
    logic [23:0] prev_cnt = '0;
    logic prev_busy = 1'b0;
    logic [26:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // one clock; observe the DUT 1ns after the edge and score period strobes
    task automatic tick();
        @(posedge Clk100m);
        #1;
        cyc++;
        if (Rstn && bus.period_vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL period_vld_unexpected: actual=strobe period=%0d expected=no strobe", bus.period);
            end else begin
                chk("period_sb", 32'(bus.period), 32'(exp_q.pop_front()));
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.pulse_cnt != prev_cnt) begin
            cnt_chg_cyc = cyc;
            if (bus.pulse_cnt == 24'd4 && prev_cnt == 24'd3)
                cnt4_cyc = cyc;
        end
        prev_cnt = bus.pulse_cnt;
        if (prev_busy && !bus.busy)
            busy_fall_cyc = cyc;
        prev_busy = bus.busy;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        repeat (3) tick();
    endtask

    // every pulse after the first of a train from IDLE yields a period strobe
    task automatic run_train(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            if (i > 0)
                exp_q.push_back(27'(hi + lo));
            bus.step_in = 1'b1;
            repeat (hi) tick();
            bus.step_in = 1'b0;
            repeat (lo) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vbase;
        int dbase;

        vecs[0] = '{dir: 1'b0, n: 10, hi: 5, lo: 5, pos: 32'd10,         cnt: 24'd10, period: 27'd10, nvld: 9};
        vecs[1] = '{dir: 1'b1, n: 10, hi: 5, lo: 5, pos: 32'hFFFF_FFF6, cnt: 24'd10, period: 27'd10, nvld: 9};
        vecs[2] = '{dir: 1'b0, n: 4,  hi: 2, lo: 2, pos: 32'd4,          cnt: 24'd4,  period: 27'd4,  nvld: 3};
        vecs[3] = '{dir: 1'b1, n: 3,  hi: 3, lo: 6, pos: 32'hFFFF_FFFD, cnt: 24'd3,  period: 27'd9,  nvld: 2};
        vecs[4] = '{dir: 1'b0, n: 1,  hi: 2, lo: 3, pos: 32'd1,          cnt: 24'd1,  period: 27'd9,  nvld: 0};

        Rstn         = 1'b0;
        bus.step_in  = 1'b0;
        bus.dir_in   = 1'b0;
        bus.clr      = 1'b0;
        bus.target_p = 1'b0;
        bus.target   = '0;
        bus.idle_lim = '0;
        repeat (3) tick();

        chk("rst_pos",        bus.pos,               32'd0);
        chk("rst_pulse_cnt",  32'(bus.pulse_cnt),    32'd0);
        chk("rst_period",     32'(bus.period),       32'd0);
        chk("rst_period_vld", 32'(bus.period_vld),   32'd0);
        chk("rst_busy",       32'(bus.busy),         32'd0);
        chk("rst_done",       32'(bus.done),         32'd0);
        chk("rst_dir_err",    32'(bus.dir_err),      32'd0);

        Rstn = 1'b1;
        repeat (2) tick();

        // table of trains, each started from a clr
        for (int i = 0; i < 5; i++) begin
            bus.dir_in = vecs[i].dir;
            do_clr();
            vbase = vld_cnt;
            run_train(vecs[i].n, vecs[i].hi, vecs[i].lo);
            repeat (4) tick();
            chk($sformatf("v%0d_pos", i),       bus.pos,                  vecs[i].pos);
            chk($sformatf("v%0d_pulse_cnt", i), 32'(bus.pulse_cnt),       32'(vecs[i].cnt));
            chk($sformatf("v%0d_period", i),    32'(bus.period),          32'(vecs[i].period));
            chk($sformatf("v%0d_nvld", i),      32'(vld_cnt - vbase),     32'(vecs[i].nvld));
            chk($sformatf("v%0d_busy", i),      32'(bus.busy),            32'd1);
            chk($sformatf("v%0d_dir_err", i),   32'(bus.dir_err),         32'd0);
            chk($sformatf("v%0d_sb_empty", i),  32'(exp_q.size()),        32'd0);
        end

        // latency: pos moves on the 3rd edge counting the one that samples step high
        bus.dir_in = 1'b0;
        do_clr();
        bus.step_in = 1'b1;
        tick();
        tick();
        chk("lat_pos_early", bus.pos, 32'd0);
        tick();
        chk("lat_pos", bus.pos, 32'd1);
        bus.step_in = 1'b0;
        repeat (4) tick();

        // target=4 then 6 pulses: exactly one done, one cycle after count hits 4
        do_clr();
        bus.target   = 24'd4;
        bus.target_p = 1'b1;
        tick();
        bus.target_p = 1'b0;
        dbase = done_cnt;
        run_train(6, 5, 5);
        repeat (4) tick();
        chk("tgt_done_count", 32'(done_cnt - dbase), 32'd1);
        chk("tgt_done_delay", 32'(done_cyc - cnt4_cyc), 32'd1);

        // target=0 with pulse_cnt=0: done two cycles after the target_p cycle
        do_clr();
        bus.target   = 24'd0;
        bus.target_p = 1'b1;
        tick();
        bus.target_p = 1'b0;
        chk("tgt0_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("tgt0_done", 32'(bus.done), 32'd1);
        tick();
        chk("tgt0_done_late", 32'(bus.done), 32'd0);

        // target_p coincident with a rise compares against the incremented count
        do_clr();
        bus.target  = 24'd1;
        bus.step_in = 1'b1;
        tick();
        tick();
        bus.target_p = 1'b1;
        tick();
        bus.target_p = 1'b0;
        chk("tgtco_cnt", 32'(bus.pulse_cnt), 32'd1);
        chk("tgtco_done_early", 32'(bus.done), 32'd0);
        tick();
        chk("tgtco_done", 32'(bus.done), 32'd1);
        bus.step_in = 1'b0;
        repeat (4) tick();

        // idle timeout 50: busy falls 51 cycles after the last counted rise
        do_clr();
        bus.idle_lim = 27'd50;
        run_train(3, 5, 5);
        for (int k = 0; k < 200 && bus.busy; k++)
            tick();
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual=busy still 1 expected=busy 0 within 200 cycles");
        end else begin
            chk("idle_fall_delay", 32'(busy_fall_cyc - cnt_chg_cyc), 32'd51);
        end
        chk("idle_sb_empty", 32'(exp_q.size()), 32'd0);

        bus.idle_lim = 27'd0;
        do_clr();
        run_train(2, 5, 5);
        repeat (200) tick();
        chk("idle_disabled_busy", 32'(bus.busy), 32'd1);

        // dir toggled while step high -> sticky dir_err
        do_clr();
        bus.dir_in  = 1'b0;
        bus.step_in = 1'b1;
        repeat (4) tick();
        bus.dir_in = 1'b1;
        repeat (4) tick();
        bus.step_in = 1'b0;
        repeat (4) tick();
        chk("dirr_set", 32'(bus.dir_err), 32'd1);
        chk("dirr_pos", bus.pos, 32'd1);
        bus.dir_in = 1'b0;
        repeat (10) tick();
        chk("dirr_sticky", 32'(bus.dir_err), 32'd1);

        // clr coincident with a rise drops the rise and clears status
        bus.step_in = 1'b1;
        tick();
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clrco_pos",       bus.pos,               32'd0);
        chk("clrco_pulse_cnt", 32'(bus.pulse_cnt),    32'd0);
        chk("clrco_dir_err",   32'(bus.dir_err),      32'd0);
        chk("clrco_busy",      32'(bus.busy),         32'd0);
        repeat (3) tick();
        chk("clrco_pos_held",  bus.pos,               32'd0);
        bus.step_in = 1'b0;
        repeat (4) tick();

        // reset pulsed mid-train: outputs clear without a clock edge
        do_clr();
        run_train(3, 5, 5);
        tick();
        Rstn = 1'b0;
        #2;
        chk("mrst_pos",       bus.pos,              32'd0);
        chk("mrst_pulse_cnt", 32'(bus.pulse_cnt),   32'd0);
        chk("mrst_period",    32'(bus.period),      32'd0);
        chk("mrst_busy",      32'(bus.busy),        32'd0);
        repeat (2) tick();
        Rstn = 1'b1;
        tick();
        vbase = vld_cnt;
        run_train(1, 5, 5);
        repeat (3) tick();
        chk("mrst_pos_after",  bus.pos,             32'd1);
        chk("mrst_cnt_after",  32'(bus.pulse_cnt),  32'd1);
        chk("mrst_no_vld",     32'(vld_cnt - vbase), 32'd0);
        chk("mrst_busy_after", 32'(bus.busy),       32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
